// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - byte-write and transmitter-launch signals of the UART TX feeder
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic                  tx_busy;

  // master: system writer plus transmitter; slave: the feeder itself
  modport master (
    output wr_data, wr_en, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_data_valid
  );

  modport slave (
    input  wr_data, wr_en, tx_busy,
    output full, empty, count, overflow, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO byte buffer draining one frame at a time into a UART transmitter
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic             clk,
  input logic             rst,
  uart_tx_feeder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full  = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (count_q == '0);
  // a full FIFO rejects writes even when a pop frees a slot on the same edge
  assign push  = bus.wr_en && !full;
  assign pop   = (state_q == IDLE) && !empty && !bus.tx_busy;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end
      count_q    <= count_d;
      overflow_q <= bus.wr_en && full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_busy) begin
            tx_valid_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tx_valid_q <= 1'b0;
          if (!bus.tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_valid_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed scoreboard bench for uart_tx_feeder with a busy-line transmitter model
module tb_uart_tx_feeder;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   launches = 0;
  int   busy_len = 10;
  bit   tx_hold  = 1'b0;
  logic [7:0] sb [$];

  uart_tx_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit drop);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (!drop) sb.push_back(b);
    step();
    bus.wr_en = 1'b0;
    check("overflow_after_write", {31'd0, bus.overflow}, {31'd0, drop});
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.tx_busy || bus.tx_data_valid || !bus.empty) && n < 2000) begin
      step();
      n++;
    end
    check(tag, sb.size(), 0);
    check({tag, "_idle"}, {30'd0, bus.tx_busy, bus.tx_data_valid}, 32'd0);
  endtask

  // Transmitter: accepts on valid && !busy, raises busy one cycle later for busy_len cycles
  initial begin : tx_model
    int  busy_cnt = 0;
    bit  pending  = 1'b0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        pending  = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end else if (pending) begin
        busy_cnt = busy_len;
        pending  = 1'b0;
      end else if (bus.tx_data_valid && !bus.tx_busy) begin
        launches++;
        pending = 1'b1;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL unexpected_launch observed=0x%0h expected=none", bus.tx_data);
        end else begin
          check("tx_data_order", {24'd0, bus.tx_data}, {24'd0, sb.pop_front()});
        end
      end
      bus.tx_busy = tx_hold || (busy_cnt > 0);
    end
  end

  initial begin : stimulus
    int n;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // reset state
    step();
    step();
    check("rst_valid", {31'd0, bus.tx_data_valid}, 32'd0);
    check("rst_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_count", {28'd0, bus.count}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    rst = 1'b0;
    step();

    // single byte: one-cycle write-to-valid, valid drops the cycle after busy rises
    wr(8'hA5, 1'b0);
    check("single_count", {28'd0, bus.count}, 32'd1);
    check("single_not_empty", {31'd0, bus.empty}, 32'd0);
    step();
    check("single_valid", {31'd0, bus.tx_data_valid}, 32'd1);
    check("single_data", {24'd0, bus.tx_data}, 32'hA5);
    check("single_empty_after_pop", {31'd0, bus.empty}, 32'd1);
    step();
    check("single_valid_held", {31'd0, bus.tx_data_valid}, 32'd1);
    step();
    check("single_busy_seen", {31'd0, bus.tx_busy}, 32'd1);
    check("single_valid_dropped", {31'd0, bus.tx_data_valid}, 32'd0);
    check("single_data_held", {24'd0, bus.tx_data}, 32'hA5);
    wait_drain("single_drain");

    // burst of three
    wr(8'h11, 1'b0);
    check("burst_count1", {28'd0, bus.count}, 32'd1);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    check("burst_count3", {28'd0, bus.count}, 32'd2);
    wait_drain("burst_drain");

    // overflow with stalled transmitter
    tx_hold = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) wr(8'h40 + 8'(i), 1'b0);
    check("ovf_full", {31'd0, bus.full}, 32'd1);
    check("ovf_count8", {28'd0, bus.count}, 32'd8);
    wr(8'h48, 1'b1);
    check("ovf_count_held", {28'd0, bus.count}, 32'd8);
    step();
    check("ovf_pulse_single", {31'd0, bus.overflow}, 32'd0);
    tx_hold = 1'b0;
    wait_drain("ovf_drain");

    // pointer wrap with partial drains
    busy_len = 3;
    for (int i = 0; i < 20; i++) begin
      wr(8'(i), 1'b0);
      if (i % 5 == 4) begin
        n = 0;
        while (bus.count > 2 && n < 500) begin
          step();
          n++;
        end
        check("wrap_partial_drain", {31'd0, bus.count > 2}, 32'd0);
      end
    end
    wait_drain("wrap_drain");

    // simultaneous pop and write at count 4
    tx_hold = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i), 1'b0);
    check("simul_count_before", {28'd0, bus.count}, 32'd4);
    tx_hold = 1'b0;
    wr(8'h77, 1'b0);
    check("simul_count_after", {28'd0, bus.count}, 32'd4);
    check("simul_valid", {31'd0, bus.tx_data_valid}, 32'd1);
    wait_drain("simul_drain");

    // reset mid-frame in WAIT_DONE with three bytes queued
    busy_len = 10;
    for (int i = 0; i < 4; i++) wr(8'h81 + 8'(i), 1'b0);
    n = 0;
    while (!(bus.tx_busy && !bus.tx_data_valid) && n < 50) begin
      step();
      n++;
    end
    check("midrst_reached_wait", {31'd0, n < 50}, 32'd1);
    check("midrst_queued", {28'd0, bus.count}, 32'd3);
    rst = 1'b1;
    step();
    check("midrst_valid", {31'd0, bus.tx_data_valid}, 32'd0);
    check("midrst_count", {28'd0, bus.count}, 32'd0);
    check("midrst_empty", {31'd0, bus.empty}, 32'd1);
    rst = 1'b0;
    sb.delete();
    wr(8'h5A, 1'b0);
    step();
    check("postrst_valid", {31'd0, bus.tx_data_valid}, 32'd1);
    check("postrst_data", {24'd0, bus.tx_data}, 32'h5A);
    wait_drain("postrst_drain");

    check("total_launches", launches, 39);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
